tea_iter_core: RTL and testbench
================================

Name: tea_iter_core

Overview:
- Parametrised, iterative TEA block-cipher engine with a runtime encrypt/decrypt mode select.
- Computes one full Feistel cycle (two half-rounds) per clock and has a configurable round count.
- Uses valid/ready handshakes on input and output.
- Successor to the fixed-function encrypt block; intended to sit between a host register interface or stream source and a downstream consumer.

Parameters:
- ROUNDS, 32, Feistel cycles per block; legal range 1..64.
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input block and key present.
- in_ready  out  1  engine can accept a block.
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- v1  in  32  first data word.
- v2  in  32  second data word.
- key1..key4  in  32 each  128-bit key, key1 = k[0].
- out_valid  out  1  result held on v1_out/v2_out.
- out_ready  in  1  consumer accepts result.
- v1_out  out  32  result word 1.
- v2_out  out  32  result word 2.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (synchronous, wins over everything, including mid-RUN): state IDLE, round counter 0, sum 0, data regs 0, out_valid 0, v1_out/v2_out 0, busy 0. Any in-flight block is discarded without output.
- in_ready = (state == IDLE), combinational from state only. in_valid while not IDLE is ignored; no queuing.
- Accept at edge where in_valid && in_ready. On that edge:
  - Capture v1, v2, key1..4 and decrypt into internal registers; later input changes have no effect.
  - Load sum with 0 for encrypt, or with DELTA*ROUNDS mod 2^32 for decrypt (0xC6EF3720 at defaults; constant computed at elaboration).
  - Clear counter and go to RUN.
- Encrypt, one Feistel cycle per RUN edge, all arithmetic mod 2^32, shifts logical:
  - s' = sum + DELTA
  - a' = a + (((b<<4)+k0) ^ (b+s') ^ ((b>>5)+k1))
  - b' = b + (((a'<<4)+k2) ^ (a'+s') ^ ((a'>>5)+k3))
  - sum <= s'
- Decrypt, one Feistel cycle per RUN edge:
  - b' = b - (((a<<4)+k2) ^ (a+sum) ^ ((a>>5)+k3))
  - a' = a - (((b'<<4)+k0) ^ (b'+sum) ^ ((b'>>5)+k1))
  - sum <= sum - DELTA
- Counter width is $clog2(ROUNDS+1). The counter increments each RUN edge. On the edge where counter == ROUNDS-1: write the final a/b to v1_out/v2_out, set out_valid, go to DONE.
- Latency: accept at edge N; out_valid high from edge N+ROUNDS. For ROUNDS=1, DONE is reached one edge after accept.
- DONE: v1_out/v2_out/out_valid held stable while out_ready is low, for unbounded backpressure.
- On an edge with out_valid && out_ready: clear out_valid and go to IDLE. in_ready rises the next cycle, so there is no same-cycle output-to-input bypass.
- Throughput: one block per ROUNDS+2 cycles with out_ready held high.
- v1_out/v2_out keep their last value after the handshake until the next completion or reset.
- busy = (state != IDLE).

Decomposition:
- Package tea_pkg:
  - DELTA_DEFAULT.
  - State enum tea_state_t {IDLE, RUN, DONE}.
  - Function tea_sum_init(rounds, delta) returning delta*rounds mod 2^32.
- Sub-module tea_round: purely combinational single Feistel cycle.
  - Inputs: a, b, sum, k0..k3, decrypt.
  - Outputs: a', b', next sum.
  - Instantiated once; the top level holds the FSM, counter and registers.

Test Plan:
- Zero key, v1=v2=0, encrypt, ROUNDS=32 -> out_valid exactly 32 edges after accept; v1_out=0x41EA3A0A, v2_out=0x94BAA940.
- Decrypt with the same key and v1=0x41EA3A0A, v2=0x94BAA940 -> 0x00000000, 0x00000000.
- v1=0x12345678, v2=0x9ABCDEF0, keys 0x11111111/0x22222222/0x33333333/0x44444444: encrypt, then feed the result back with decrypt=1 -> original words restored.
- Backpressure: out_ready low for 10 cycles after completion -> out_valid and data stable, in_ready low; in_valid pulses during RUN/DONE are ignored; single handshake on out_ready rise.
- Reset asserted for 1 cycle at round 10 -> next cycle in_ready=1, out_valid=0, outputs 0; a subsequent zero-vector block still yields 0x41EA3A0A/0x94BAA940.
- Back-to-back blocks with out_ready and in_valid tied high, ROUNDS=8 instance -> accepts exactly every 10 cycles; each result matches the reference model; decrypt round-trip passes at ROUNDS=8 and ROUNDS=1.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared types, constants and helpers for the iterative TEA engine.
package tea_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_t;

    // Starting sum for decryption: delta * rounds, wrapped to 32 bits.
    function automatic logic [WORD_W-1:0] tea_sum_init(
        input int unsigned       rounds,
        input logic [WORD_W-1:0] delta
    );
        logic [2*WORD_W-1:0] w_prod;
        w_prod = (2*WORD_W)'(delta) * (2*WORD_W)'(rounds);
        return w_prod[WORD_W-1:0];
    endfunction

    // TEA mixing term: ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb), logical shifts.
    function automatic logic [WORD_W-1:0] tea_mix(
        input logic [WORD_W-1:0] x,
        input logic [WORD_W-1:0] s,
        input logic [WORD_W-1:0] ka,
        input logic [WORD_W-1:0] kb
    );
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_round.sv
// One full TEA Feistel cycle (two half-rounds), purely combinational.
module tea_round
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic [WORD_W-1:0] i_sum,
    input  logic [WORD_W-1:0] i_k0,
    input  logic [WORD_W-1:0] i_k1,
    input  logic [WORD_W-1:0] i_k2,
    input  logic [WORD_W-1:0] i_k3,
    input  logic              i_decrypt,
    output logic [WORD_W-1:0] o_a,
    output logic [WORD_W-1:0] o_b,
    output logic [WORD_W-1:0] o_sum
);

    logic [WORD_W-1:0] w_sum_enc;
    logic [WORD_W-1:0] w_sum_dec;
    logic [WORD_W-1:0] w_a_enc;
    logic [WORD_W-1:0] w_b_enc;
    logic [WORD_W-1:0] w_a_dec;
    logic [WORD_W-1:0] w_b_dec;

    // Encrypt advances the sum first and updates a before b.
    assign w_sum_enc = i_sum + DELTA;
    assign w_a_enc   = i_a + tea_mix(i_b, w_sum_enc, i_k0, i_k1);
    assign w_b_enc   = i_b + tea_mix(w_a_enc, w_sum_enc, i_k2, i_k3);

    // Decrypt undoes b then a with the current sum, then retreats the sum.
    assign w_b_dec   = i_b - tea_mix(i_a, i_sum, i_k2, i_k3);
    assign w_a_dec   = i_a - tea_mix(w_b_dec, i_sum, i_k0, i_k1);
    assign w_sum_dec = i_sum - DELTA;

    assign o_a   = i_decrypt ? w_a_dec   : w_a_enc;
    assign o_b   = i_decrypt ? w_b_dec   : w_b_enc;
    assign o_sum = i_decrypt ? w_sum_dec : w_sum_enc;

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA encrypt/decrypt engine: one Feistel cycle per clock,
// valid/ready on both sides, result held in DONE until consumed.
module tea_iter_core
    import tea_pkg::*;
#(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = DELTA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              decrypt,
    input  logic [WORD_W-1:0] v1,
    input  logic [WORD_W-1:0] v2,
    input  logic [WORD_W-1:0] key1,
    input  logic [WORD_W-1:0] key2,
    input  logic [WORD_W-1:0] key3,
    input  logic [WORD_W-1:0] key4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] v1_out,
    output logic [WORD_W-1:0] v2_out,
    output logic              busy
);

    localparam int unsigned       CNT_W    = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ROUNDS - 1);
    localparam logic [WORD_W-1:0] SUM_DEC0 = tea_sum_init(ROUNDS, DELTA);

    tea_state_t         r_state;
    tea_state_t         w_state_nxt;
    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_release;

    logic [CNT_W-1:0]   r_cnt;
    logic [WORD_W-1:0]  r_sum;
    logic [WORD_W-1:0]  r_a;
    logic [WORD_W-1:0]  r_b;
    logic [WORD_W-1:0]  r_k0;
    logic [WORD_W-1:0]  r_k1;
    logic [WORD_W-1:0]  r_k2;
    logic [WORD_W-1:0]  r_k3;
    logic               r_decrypt;
    logic               r_out_valid;
    logic [WORD_W-1:0]  r_v1_out;
    logic [WORD_W-1:0]  r_v2_out;

    logic [WORD_W-1:0]  w_a_nxt;
    logic [WORD_W-1:0]  w_b_nxt;
    logic [WORD_W-1:0]  w_sum_nxt;

    tea_round #(
        .DELTA(DELTA)
    ) u_round (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sum    (r_sum),
        .i_k0     (r_k0),
        .i_k1     (r_k1),
        .i_k2     (r_k2),
        .i_k3     (r_k3),
        .i_decrypt(r_decrypt),
        .o_a      (w_a_nxt),
        .o_b      (w_b_nxt),
        .o_sum    (w_sum_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Block capture, round iteration and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_sum       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_k0        <= '0;
            r_k1        <= '0;
            r_k2        <= '0;
            r_k3        <= '0;
            r_decrypt   <= 1'b0;
            r_out_valid <= 1'b0;
            r_v1_out    <= '0;
            r_v2_out    <= '0;
        end else begin
            if (w_accept) begin
                r_a       <= v1;
                r_b       <= v2;
                r_k0      <= key1;
                r_k1      <= key2;
                r_k2      <= key3;
                r_k3      <= key4;
                r_decrypt <= decrypt;
                r_sum     <= decrypt ? SUM_DEC0 : '0;
                r_cnt     <= '0;
            end
            if (w_run) begin
                r_a   <= w_a_nxt;
                r_b   <= w_b_nxt;
                r_sum <= w_sum_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_v1_out    <= w_a_nxt;
                r_v2_out    <= w_b_nxt;
                r_out_valid <= 1'b1;
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign v1_out    = r_v1_out;
    assign v2_out    = r_v2_out;

endmodule

// File: tb/tb_tea_iter_core.sv
// Directed bench for tea_iter_core at ROUNDS = 32, 8 and 1.
module tb_tea_iter_core;

    localparam logic [31:0] D = 32'h9E3779B9;

    logic        clk;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  ir;
    logic [2:0]  ordy;
    logic [2:0]  ov;
    logic [2:0]  bsy;
    logic [31:0] o1 [3];
    logic [31:0] o2 [3];
    logic        dec_s;
    logic [31:0] v1_s, v2_s, k1_s, k2_s, k3_s, k4_s;

    int checks   = 0;
    int failures = 0;

    tea_iter_core #(.ROUNDS(32)) u_r32 (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .decrypt(dec_s),
        .v1(v1_s), .v2(v2_s), .key1(k1_s), .key2(k2_s), .key3(k3_s), .key4(k4_s),
        .out_valid(ov[0]), .out_ready(ordy[0]), .v1_out(o1[0]), .v2_out(o2[0]), .busy(bsy[0])
    );
    tea_iter_core #(.ROUNDS(8)) u_r8 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .decrypt(dec_s),
        .v1(v1_s), .v2(v2_s), .key1(k1_s), .key2(k2_s), .key3(k3_s), .key4(k4_s),
        .out_valid(ov[1]), .out_ready(ordy[1]), .v1_out(o1[1]), .v2_out(o2[1]), .busy(bsy[1])
    );
    tea_iter_core #(.ROUNDS(1)) u_r1 (
        .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .decrypt(dec_s),
        .v1(v1_s), .v2(v2_s), .key1(k1_s), .key2(k2_s), .key3(k3_s), .key4(k4_s),
        .out_valid(ov[2]), .out_ready(ordy[2]), .v1_out(o1[2]), .v2_out(o2[2]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        bit          dec;
        logic [31:0] v1, v2, k0, k1, k2, k3;
        logic [31:0] e1, e2;
    } vec_t;

    function automatic int rounds_of(input int u);
        case (u)
            0:       return 32;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    // Reference TEA, written the way the classic C routine reads.
    function automatic void tea_model(input bit dec, input int rounds,
                                      input logic [31:0] a_in, b_in, k0, k1, k2, k3,
                                      output logic [31:0] a_o, output logic [31:0] b_o);
        logic [31:0] a, b, s;
        a = a_in;
        b = b_in;
        s = 32'h0;
        if (!dec) begin
            for (int i = 0; i < rounds; i++) begin
                s = s + D;
                a = a + (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
                b = b + (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
            end
        end else begin
            for (int i = 0; i < rounds; i++) s = s + D;
            for (int i = 0; i < rounds; i++) begin
                b = b - (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
                a = a - (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
                s = s - D;
            end
        end
        a_o = a;
        b_o = b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one block to instance u and wait (bounded) for its result.
    task automatic run_block(input int u, input bit d,
                             input logic [31:0] a, b, k0, k1, k2, k3,
                             output logic [31:0] r1, output logic [31:0] r2, output int lat);
        @(negedge clk);
        dec_s = d; v1_s = a; v2_s = b;
        k1_s = k0; k2_s = k1; k3_s = k2; k4_s = k3;
        iv[u] = 1'b1;
        @(posedge clk); #1;
        iv[u] = 1'b0;
        dec_s = ~d; v1_s = 32'hDEADBEEF; v2_s = ~b; k1_s = 32'hA5A5A5A5; k4_s = ~k3;
        lat = 0;
        while (!ov[u] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r1 = o1[u];
        r2 = o2[u];
        if (ordy[u]) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t        vecs [6];
    logic [31:0] r1, r2, c1, c2, ea, eb, keep1, keep2;
    int          lat;
    int          acc_t [$];
    logic [63:0] expq [$];
    logic [63:0] e;

    initial begin
        rst = 1'b1; iv = 3'b000; ordy = 3'b111;
        dec_s = 1'b0; v1_s = '0; v2_s = '0; k1_s = '0; k2_s = '0; k3_s = '0; k4_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(ir[0]), 32'd1);
        chk("reset_out_valid", 32'(ov[0]), 32'd0);
        chk("reset_v1_out", o1[0], 32'h0);
        chk("reset_v2_out", o2[0], 32'h0);
        chk("reset_busy", 32'(bsy[0]), 32'd0);

        vecs[0] = '{0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h41EA3A0A, 32'h94BAA940};
        vecs[1] = '{0, 1'b1, 32'h41EA3A0A, 32'h94BAA940, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h11111111, 32'h22222222,
                    32'h33333333, 32'h44444444, 32'h0, 32'h0};
        vecs[3] = '{1, 1'b0, 32'h01234567, 32'h89ABCDEF, 32'hA, 32'hB, 32'hC, 32'hD, 32'h0, 32'h0};
        vecs[4] = '{2, 1'b0, 32'h01234567, 32'h89ABCDEF, 32'hA, 32'hB, 32'hC, 32'hD, 32'h0, 32'h0};
        vecs[5] = '{2, 1'b1, 32'hCAFEBABE, 32'h0BADF00D, 32'hFFFFFFFF, 32'h80000000,
                    32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h0};
        for (int i = 2; i < 6; i++) begin
            tea_model(vecs[i].dec, rounds_of(vecs[i].inst), vecs[i].v1, vecs[i].v2,
                      vecs[i].k0, vecs[i].k1, vecs[i].k2, vecs[i].k3, ea, eb);
            vecs[i].e1 = ea;
            vecs[i].e2 = eb;
        end

        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].inst, vecs[i].dec, vecs[i].v1, vecs[i].v2,
                      vecs[i].k0, vecs[i].k1, vecs[i].k2, vecs[i].k3, r1, r2, lat);
            chk($sformatf("vec%0d_v1_out", i), r1, vecs[i].e1);
            chk($sformatf("vec%0d_v2_out", i), r2, vecs[i].e2);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(rounds_of(vecs[i].inst)));
        end

        // Encrypt then decrypt the ciphertext on each instance.
        for (int u = 0; u < 3; u++) begin
            run_block(u, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h11111111, 32'h22222222,
                      32'h33333333, 32'h44444444, c1, c2, lat);
            run_block(u, 1'b1, c1, c2, 32'h11111111, 32'h22222222,
                      32'h33333333, 32'h44444444, r1, r2, lat);
            chk($sformatf("roundtrip%0d_v1", u), r1, 32'h12345678);
            chk($sformatf("roundtrip%0d_v2", u), r2, 32'h9ABCDEF0);
        end

        // Backpressure with stray in_valid pulses in RUN and DONE.
        ordy[0] = 1'b0;
        @(negedge clk);
        dec_s = 1'b0; v1_s = '0; v2_s = '0; k1_s = '0; k2_s = '0; k3_s = '0; k4_s = '0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); iv[0] = 1'b1; v1_s = 32'h1;
        @(negedge clk); iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        keep1 = o1[0];
        keep2 = o2[0];
        chk("bp_v1_out", keep1, 32'h41EA3A0A);
        chk("bp_v2_out", keep2, 32'h94BAA940);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_out_valid", 32'(ov[0]), 32'd1);
            chk("bp_hold_in_ready", 32'(ir[0]), 32'd0);
            chk("bp_hold_v1_out", o1[0], keep1);
            chk("bp_hold_v2_out", o2[0], keep2);
            iv[0] = (i == 3);
        end
        iv[0] = 1'b0;
        @(negedge clk); ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 32'(ov[0]), 32'd0);
        chk("bp_release_in_ready", 32'(ir[0]), 32'd1);
        @(posedge clk); #1;
        chk("bp_single_handshake", 32'(ov[0]), 32'd0);
        chk("bp_no_stray_accept", 32'(bsy[0]), 32'd0);
        chk("bp_v1_kept", o1[0], keep1);

        // Reset in the middle of a block.
        @(negedge clk);
        dec_s = 1'b0; v1_s = 32'h12345678; v2_s = 32'h9ABCDEF0;
        k1_s = 32'h11111111; k2_s = 32'h22222222; k3_s = 32'h33333333; k4_s = 32'h44444444;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_in_ready", 32'(ir[0]), 32'd1);
        chk("midrst_out_valid", 32'(ov[0]), 32'd0);
        chk("midrst_v1_out", o1[0], 32'h0);
        chk("midrst_v2_out", o2[0], 32'h0);
        chk("midrst_busy", 32'(bsy[0]), 32'd0);
        run_block(0, 1'b0, '0, '0, '0, '0, '0, '0, r1, r2, lat);
        chk("postrst_v1_out", r1, 32'h41EA3A0A);
        chk("postrst_v2_out", r2, 32'h94BAA940);
        chk("postrst_latency", 32'(lat), 32'd32);

        // Back-to-back streaming on the ROUNDS=8 instance.
        ordy[1] = 1'b1;
        for (int cyc = 0; cyc < 75; cyc++) begin
            @(negedge clk);
            if (ov[1]) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("b2b_v1_out", o1[1], e[63:32]);
                    chk("b2b_v2_out", o2[1], e[31:0]);
                end else begin
                    chk("b2b_unexpected_result", 32'(ov[1]), 32'd0);
                end
            end
            iv[1] = (cyc < 60);
            dec_s = 1'b0;
            v1_s = 32'h10000000 + 32'(cyc * 7919);
            v2_s = 32'hF0000000 ^ 32'(cyc * 104729);
            k1_s = 32'(cyc); k2_s = ~32'(cyc); k3_s = 32'hC0FFEE00 + 32'(cyc); k4_s = 32'h5A5A5A5A;
            if (ir[1] && iv[1]) begin
                tea_model(1'b0, 8, v1_s, v2_s, k1_s, k2_s, k3_s, k4_s, ea, eb);
                expq.push_back({ea, eb});
                acc_t.push_back(cyc);
            end
        end
        iv[1] = 1'b0;
        chk("b2b_accept_count", 32'(acc_t.size()), 32'd6);
        chk("b2b_all_results_seen", 32'(expq.size()), 32'd0);
        for (int i = 1; i < acc_t.size(); i++) begin
            chk($sformatf("b2b_interval%0d", i), 32'(acc_t[i] - acc_t[i-1]), 32'd10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
